// File: rtl/mdu_div_sequencer.sv
// Multi-cycle RISC-V M-extension divide/remainder sequencer.
// It runs a radix-2 restoring divide on magnitudes, then applies sign fix-up.
module mdu_div_sequencer (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] OP_A,
   input  logic [31:0] OP_B,
   input  logic [4:0]  RD_IN,
   input  logic        FLUSH,
   output logic        BUSY,
   output logic        STALL,
   output logic        RESULT_VALID,
   output logic [31:0] RESULT,
   output logic [4:0]  RD_OUT
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q;
   logic [5:0]  count_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] divisor_q;
   logic        isRem_q;
   logic        negQuo_q;
   logic        negRem_q;
   logic [4:0]  rdTag_q;
   logic        busy_q;
   logic        valid_q;
   logic [31:0] result_q;
   logic [4:0]  rdOut_q;

   logic        accept_d;
   logic        signedOp_d;
   logic        aNeg_d;
   logic        bNeg_d;
   logic [31:0] aMag_d;
   logic [31:0] bMag_d;
   logic        divZero_d;
   logic        overflow_d;
   logic [32:0] shifted_d;
   logic [32:0] diff_d;

   // diff_d[32] set means the trial subtraction borrowed, so the partial remainder is restored.
   always_comb begin
      accept_d   = START & FUNCT3[2] & ~FLUSH & (state_q == IDLE);
      signedOp_d = ~FUNCT3[0];
      aNeg_d     = signedOp_d & OP_A[31];
      bNeg_d     = signedOp_d & OP_B[31];
      aMag_d     = aNeg_d ? (32'd0 - OP_A) : OP_A;
      bMag_d     = bNeg_d ? (32'd0 - OP_B) : OP_B;
      divZero_d  = (OP_B == 32'd0);
      overflow_d = signedOp_d & (OP_A == 32'h8000_0000) & (OP_B == 32'hFFFF_FFFF);
      shifted_d  = {rem_q, quo_q[31]};
      diff_d     = shifted_d - {1'b0, divisor_q};
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q  <= IDLE;
         count_q  <= 6'd0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= 32'd0;
         rdOut_q  <= 5'd0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  rdTag_q <= RD_IN;
                  isRem_q <= FUNCT3[1];
                  busy_q  <= 1'b1;
                  count_q <= 6'd0;
                  if (divZero_d) begin
                     quo_q    <= 32'hFFFF_FFFF;
                     rem_q    <= OP_A;
                     negQuo_q <= 1'b0;
                     negRem_q <= 1'b0;
                     state_q  <= DONE;
                  end else if (overflow_d) begin
                     quo_q    <= 32'h8000_0000;
                     rem_q    <= 32'd0;
                     negQuo_q <= 1'b0;
                     negRem_q <= 1'b0;
                     state_q  <= DONE;
                  end else begin
                     quo_q     <= aMag_d;
                     rem_q     <= 32'd0;
                     divisor_q <= bMag_d;
                     negQuo_q  <= aNeg_d ^ bNeg_d;
                     negRem_q  <= aNeg_d;
                     state_q   <= CALC;
                  end
               end
            end
            CALC: begin
               if (FLUSH) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  count_q <= 6'd0;
               end else begin
                  rem_q   <= diff_d[32] ? shifted_d[31:0] : diff_d[31:0];
                  quo_q   <= {quo_q[30:0], ~diff_d[32]};
                  count_q <= count_q + 6'd1;
                  if (count_q == 6'd31) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               count_q <= 6'd0;
               if (!FLUSH) begin
                  if (isRem_q) begin
                     result_q <= negRem_q ? (32'd0 - rem_q) : rem_q;
                  end else begin
                     result_q <= negQuo_q ? (32'd0 - quo_q) : quo_q;
                  end
                  rdOut_q <= rdTag_q;
                  valid_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY         = busy_q;
   assign STALL        = busy_q | (START & FUNCT3[2] & (state_q == IDLE) & ~FLUSH);
   assign RESULT_VALID = valid_q;
   assign RESULT       = result_q;
   assign RD_OUT       = rdOut_q;

endmodule
